dma_prio_arbiter: RTL and testbench

DMA_PRIO_ARBITER -- requirements
Module: dma_prio_arbiter

---
 rtl/dma_pkg.sv | 9 +
 rtl/dma_prio_rr_pick.sv | 36 +++
 rtl/dma_prio_arbiter.sv | 89 ++++++++
 tb/tb_dma_prio_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared types and defaults for the DMA priority arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   prio_t      : priority level at the default width
package dma_pkg;
   localparam int DMA_CH_DEF = 8;
   localparam int PRT_W_DEF  = 4;
   typedef enum logic {IDLE, GRANT} arb_state_t;
   typedef logic [PRT_W_DEF-1:0] prio_t;
endpackage

// File: rtl/dma_prio_rr_pick.sv
// dma_prio_rr_pick: combinational highest-priority pick with round-robin tie break.
//   elig   : mask of channels allowed to win
//   levels : packed per-channel priority levels, channel n at [n*PRT_W +: PRT_W]
//   rr_ptr : last granted channel; search starts at rr_ptr+1
//   win    : winning channel index (0 when none)
//   found  : any eligible channel present
import dma_pkg::*;
module dma_prio_rr_pick #(
   parameter int DMA_CH = DMA_CH_DEF,
   parameter int PRT_W  = PRT_W_DEF,
   localparam int ID_W  = $clog2(DMA_CH)
) (
   input  logic [DMA_CH-1:0]       elig,
   input  logic [DMA_CH*PRT_W-1:0] levels,
   input  logic [ID_W-1:0]         rr_ptr,
   output logic [ID_W-1:0]         win,
   output logic                    found
);
   logic [PRT_W-1:0] best;
   int idx;
   // Scan in round-robin order; strict '>' keeps the earliest channel among equal levels.
   always_comb begin
      found = 1'b0;
      win   = '0;
      best  = '0;
      idx   = 0;
      for (int k = 1; k <= DMA_CH; k++) begin
         idx = (int'(rr_ptr) + k) % DMA_CH;
         if (elig[idx] && (!found || levels[idx*PRT_W +: PRT_W] > best)) begin
            found = 1'b1;
            best  = levels[idx*PRT_W +: PRT_W];
            win   = ID_W'(idx);
         end
      end
   end
endmodule

// File: rtl/dma_prio_arbiter.sv
// dma_prio_arbiter: priority arbiter for DMA channels with round-robin ties and burst limit.
//   clk, rstn        : clock, asynchronous active-low reset
//   req_i            : per-channel level request
//   priority_level_i : per-channel priority, higher wins
//   grant_o          : registered one-hot grant
//   grant_valid_o    : any grant held
//   grant_id_o       : index of granted channel, 0 when idle
//   handover_o       : pulse in the first cycle after a timeout-forced handover
import dma_pkg::*;
module dma_prio_arbiter #(
   parameter int DMA_CH        = DMA_CH_DEF,
   parameter int PRT_W         = PRT_W_DEF,
   parameter int MAX_GRANT_CYC = 16,
   localparam int ID_W         = $clog2(DMA_CH)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [DMA_CH-1:0]       req_i,
   input  logic [DMA_CH*PRT_W-1:0] priority_level_i,
   output logic [DMA_CH-1:0]       grant_o,
   output logic                    grant_valid_o,
   output logic [ID_W-1:0]         grant_id_o,
   output logic                    handover_o
);
   localparam int CNT_W = (MAX_GRANT_CYC > 0) ? $clog2(MAX_GRANT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_SAT = (MAX_GRANT_CYC > 0) ? CNT_W'(MAX_GRANT_CYC) : '1;
   arb_state_t        state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [ID_W-1:0]   rr_ptr, rr_n, id_n, win;
   logic [DMA_CH-1:0] grant_n, elig;
   logic              ho_n, found, owner_req, limit_hit;
   // While a grant is held the owner never competes: that covers both release and forced handover.
   assign elig      = (state == GRANT) ? (req_i & ~grant_o) : req_i;
   assign owner_req = |(req_i & grant_o);
   assign limit_hit = (MAX_GRANT_CYC > 0) && (cnt == CNT_SAT);
   dma_prio_rr_pick #(.DMA_CH(DMA_CH), .PRT_W(PRT_W)) u_pick (
      .elig   (elig),
      .levels (priority_level_i),
      .rr_ptr (rr_ptr),
      .win    (win),
      .found  (found)
   );
   always_comb begin
      state_n = state;
      grant_n = grant_o;
      id_n    = grant_id_o;
      cnt_n   = cnt;
      rr_n    = rr_ptr;
      ho_n    = 1'b0;
      if (state == IDLE || !owner_req || limit_hit) begin
         if (found) begin
            state_n = GRANT;
            grant_n = DMA_CH'(1) << win;
            id_n    = win;
            cnt_n   = CNT_W'(1);
            rr_n    = win;
            ho_n    = (state == GRANT) && owner_req;
         end else if (state == GRANT && owner_req) begin
            cnt_n = CNT_W'(1);
         end else begin
            state_n = IDLE;
            grant_n = '0;
            id_n    = '0;
            cnt_n   = '0;
         end
      end else begin
         cnt_n = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         grant_o       <= '0;
         grant_valid_o <= 1'b0;
         grant_id_o    <= '0;
         handover_o    <= 1'b0;
         cnt           <= '0;
         rr_ptr        <= ID_W'(DMA_CH - 1);
      end else begin
         state         <= state_n;
         grant_o       <= grant_n;
         grant_valid_o <= |grant_n;
         grant_id_o    <= id_n;
         handover_o    <= ho_n;
         cnt           <= cnt_n;
         rr_ptr        <= rr_n;
      end
   end
endmodule

// File: tb/tb_dma_prio_arbiter.sv
// tb_dma_prio_arbiter: directed scoreboard bench for dma_prio_arbiter.
module tb_dma_prio_arbiter;
   localparam int N = 8;
   localparam int W = 4;
   typedef struct packed {
      logic [N-1:0] g;
      logic         h;
   } exp_t;
   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] lvl = '0;
   logic [N-1:0]   grant;
   logic           gv;
   logic [2:0]     gid;
   logic           ho;
   exp_t           q[$];
   int             n_run = 0;
   int             n_fail = 0;
   always #5 clk = ~clk;
   dma_prio_arbiter #(.DMA_CH(N), .PRT_W(W), .MAX_GRANT_CYC(16)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .req_i            (req),
      .priority_level_i (lvl),
      .grant_o          (grant),
      .grant_valid_o    (gv),
      .grant_id_o       (gid),
      .handover_o       (ho)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic [N-1:0] g, input logic h);
      q.push_back('{g: g, h: h});
   endtask
   task automatic pop_chk();
      exp_t e;
      logic [31:0] id;
      e  = q.pop_front();
      id = 0;
      for (int i = 0; i < N; i++) if (e.g[i]) id = i;
      chk("grant_o", 32'(grant), 32'(e.g));
      chk("grant_valid_o", 32'(gv), 32'(|e.g));
      chk("grant_id_o", 32'(gid), id);
      chk("handover_o", 32'(ho), 32'(e.h));
   endtask
   task automatic cyc(input logic [N-1:0] g, input logic h);
      push(g, h);
      @(posedge clk);
      #1;
      pop_chk();
   endtask
   task automatic cycn(input int n, input logic [N-1:0] g);
      for (int i = 0; i < n; i++) cyc(g, 1'b0);
   endtask
   initial begin
      #1;
      push('0, 1'b0);
      pop_chk();
      #12 rstn = 1'b1;
      // priority order with zero-bubble release
      for (int c = 0; c < N; c++) lvl[c*W +: W] = W'(c);
      req = 8'b0100_0111;
      cyc(8'h40, 1'b0);
      cyc(8'h40, 1'b0);
      req = 8'h07;
      cyc(8'h04, 1'b0);
      req = 8'h03;
      cyc(8'h02, 1'b0);
      req = 8'h01;
      cyc(8'h01, 1'b0);
      req = 8'h00;
      cyc(8'h00, 1'b0);
      // round robin among equal levels, restart from reset pointer
      rstn = 1'b0;
      #2 rstn = 1'b1;
      lvl = '0;
      req = 8'hFF;
      for (int c = 0; c < N; c++) begin
         cycn(2, 8'(1 << c));
         req[c] = 1'b0;
      end
      cyc(8'h00, 1'b0);
      // timeout handover between two held requesters
      req = 8'h28;
      cycn(16, 8'h08);
      cyc(8'h20, 1'b1);
      cycn(15, 8'h20);
      cyc(8'h08, 1'b1);
      req = 8'h00;
      cyc(8'h00, 1'b0);
      // lone requester keeps grant through timeouts
      req = 8'h10;
      cycn(40, 8'h10);
      req = 8'h00;
      cyc(8'h00, 1'b0);
      // release exactly at timeout edge is not a handover
      req = 8'h28;
      cycn(16, 8'h20);
      req = 8'h08;
      cyc(8'h08, 1'b0);
      req = 8'h00;
      cyc(8'h00, 1'b0);
      // level change during a held grant does not preempt
      lvl[7*W +: W] = 4'd7;
      lvl[2*W +: W] = 4'd2;
      req = 8'h84;
      cyc(8'h80, 1'b0);
      lvl[2*W +: W] = 4'd15;
      cycn(3, 8'h80);
      req = 8'h04;
      cyc(8'h04, 1'b0);
      req = 8'h00;
      cyc(8'h00, 1'b0);
      // asynchronous reset mid-grant
      lvl = '0;
      req = 8'h02;
      cycn(2, 8'h02);
      #2 rstn = 1'b0;
      #1;
      push('0, 1'b0);
      pop_chk();
      req = 8'h03;
      #1 rstn = 1'b1;
      cyc(8'h01, 1'b0);
      req = 8'h00;
      cyc(8'h00, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
